// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types and constants for the seven-segment scan controller
package sevenseg_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam int DEF_TICK_DIV  = 100000;
  localparam int DEF_BLANK_CYC = 4;

  // Code the downstream 4-bit-to-segment decoder renders as all segments off
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - per-slot cycle counter with slot-wrap and blank-window flags
module scan_tick_gen
  import sevenseg_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap_o,
  output logic blank_next_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CNT_MAX);
  assign cnt_d  = wrap_o ? '0 : cnt_q + 1'b1;

  // Look-ahead so the FSM register lands in BLANK exactly while cnt < BLANK_CYC
  assign blank_next_o = (int'(cnt_d) < BLANK_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed seven-segment scan with shadowed value and anti-ghost blanking
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [3:0]            digit,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  dp_n,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam scan_state_e RST_STATE = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, sh_val_q;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q;
  logic                  pending_q, pending_d;
  logic [N_DIGITS-1:0]   en_q;
  logic                  lz_q;

  logic                  wrap, blank_next, swap, lit, suppressed;
  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   zero_run;

  scan_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrap_o       (wrap),
    .blank_next_o (blank_next)
  );

  assign swap = wrap && (idx_q == IDX_MAX);

  // zero_run[i]: active nibbles i..N_DIGITS-1 are all zero
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign nib[g] = act_val_q[4*g +: 4];
    if (g == N_DIGITS - 1) begin : g_top
      assign zero_run[g] = (nib[g] == 4'h0);
    end else begin : g_low
      assign zero_run[g] = zero_run[g+1] & (nib[g] == 4'h0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (!blank_next) state_d = ST_DRIVE;
      ST_DRIVE: if (blank_next)  state_d = ST_BLANK;
      default:  state_d = RST_STATE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pending_d = pending_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    // A load landing on the swap cycle bypasses the shadow so it is not lost for a frame
    if (swap) begin
      pending_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
      end else if (pending_q) begin
        act_val_d = sh_val_q;
        act_dp_d  = sh_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      idx_q     <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      en_q      <= '0;
      lz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pending_q <= pending_d;
      en_q      <= digit_en;
      lz_q      <= lz_blank;
      if (load) begin
        sh_val_q <= value;
        sh_dp_q  <= dp_in;
      end
    end
  end

  assign suppressed = lz_q && (idx_q != '0) && zero_run[idx_q];
  assign lit        = (state_q == ST_DRIVE) && en_q[idx_q] && !suppressed;

  always_comb begin
    an_n = '1;
    if (lit) an_n[idx_q] = 1'b0;
  end

  assign digit      = nib[idx_q];
  assign dp_n       = ~(lit & act_dp_q[idx_q]);
  assign pending    = pending_q;
  assign frame_done = swap;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - scoreboard bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_blank;
  logic [3:0]  digit_en;
  logic [3:0]  digit;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        pending;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] an;
    logic [15:0] dig;
    logic [3:0]  dp;
  } frame_t;

  frame_t sb[$];

  sevenseg_scan_ctrl #(
    .N_DIGITS  (4),
    .TICK_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .lz_blank   (lz_blank),
    .digit_en   (digit_en),
    .digit      (digit),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples each slot mid-drive, checks the frame against the scoreboard at frame_done
  int         pos = 0;
  bit         synced = 0;
  bit         blank_bad = 0;
  int         multi_low = 0;
  logic [3:0] o_an [4];
  logic [3:0] o_dig [4];
  logic       o_dp [4];
  frame_t     exp_f;

  always @(negedge clk) begin
    logic [1:0] sl;
    int         off;
    if (!rst_n) begin
      synced = 0;
      pos    = 0;
    end else begin
      if ($countones(~an_n) > 1) multi_low++;
      sl  = 2'(pos >> 3);
      off = pos & 7;
      if (synced) begin
        if (off < 2 && an_n != 4'hF) blank_bad = 1;
        if (off == 4) begin
          o_an[sl]  = an_n;
          o_dig[sl] = digit;
          o_dp[sl]  = dp_n;
        end
      end
      if (frame_done) begin
        if (synced) begin
          check("frame_period", pos, 31);
          if (sb.size() > 0) begin
            exp_f = sb.pop_front();
            check("frame_an",  {o_an[3], o_an[2], o_an[1], o_an[0]}, exp_f.an);
            check("frame_dig", {o_dig[3], o_dig[2], o_dig[1], o_dig[0]}, exp_f.dig);
            check("frame_dp",  {o_dp[3], o_dp[2], o_dp[1], o_dp[0]}, exp_f.dp);
            check("blank_window", blank_bad, 0);
          end
        end
        synced    = 1;
        pos       = 0;
        blank_bad = 0;
      end else begin
        pos++;
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (n >= 100) check("frame_done_timeout", frame_done, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic frame_start(input frame_t f);
    @(posedge clk);
    #1;
    sb.push_back(f);
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = '0;
    dp_in    = '0;
    load     = 1'b0;
    lz_blank = 1'b0;
    digit_en = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_an_n", an_n, 4'hF);
    check("rst_dp_n", dp_n, 1);
    check("rst_digit", digit, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pending", pending, 0);

    rst_n = 1'b1;
    #1 check("cyc0_an_n", an_n, 4'hF);
    @(negedge clk);
    check("cyc1_an_n", an_n, 4'hF);
    @(negedge clk);
    check("cyc2_an_n", an_n, 4'hE);
    check("cyc2_digit", digit, 0);

    wait_frame();
    frame_start('{an: 16'h7BDE, dig: 16'h0000, dp: 4'hF});
    repeat (8) @(negedge clk);
    do_load(16'h1234, 4'b0100);
    check("pending_after_load", pending, 1);

    wait_frame();
    check("pending_before_swap", pending, 1);
    frame_start('{an: 16'h7BDE, dig: 16'h1234, dp: 4'b1011});
    check("pending_after_swap", pending, 0);
    lz_blank = 1'b1;
    repeat (8) @(negedge clk);
    do_load(16'h0500, 4'b0000);

    wait_frame();
    frame_start('{an: 16'hFBDE, dig: 16'h0500, dp: 4'hF});
    repeat (8) @(negedge clk);
    do_load(16'h0000, 4'b0000);

    wait_frame();
    frame_start('{an: 16'hFFFE, dig: 16'h0000, dp: 4'hF});
    repeat (6) @(negedge clk);
    do_load(16'hAAAA, 4'hF);
    repeat (4) @(negedge clk);
    do_load(16'h5555, 4'h0);
    check("pending_two_loads", pending, 1);

    wait_frame();
    frame_start('{an: 16'h7BDE, dig: 16'h5555, dp: 4'hF});
    lz_blank = 1'b0;

    wait_frame();
    value = 16'h9999;
    dp_in = 4'hF;
    load  = 1'b1;
    frame_start('{an: 16'h7FDF, dig: 16'h9999, dp: 4'b0101});
    load     = 1'b0;
    digit_en = 4'b1010;
    check("pending_swap_cycle_load", pending, 0);

    repeat (12) @(negedge clk);
    do_load(16'h7777, 4'h0);
    check("pending_before_reset", pending, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_an_n", an_n, 4'hF);
    check("midreset_dp_n", dp_n, 1);
    check("midreset_digit", digit, 0);
    check("midreset_frame_done", frame_done, 0);
    check("midreset_pending", pending, 0);
    sb.delete();
    digit_en = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_frame();
    frame_start('{an: 16'h7BDE, dig: 16'h0000, dp: 4'hF});
    wait_frame();
    @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("multi_anode_low", multi_low, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
